count_seq_checker: RTL and testbench



---
 rtl/count_seq_checker.sv | 159 +++++++++++++++
 tb/tb_count_seq_checker.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_seq_checker.sv
// Sequence checker for the free-running modulo counter bus.
// SEQ_CHK_HOLD_EN: a repeat of the last accepted value is a pause, not a miss.
module count_seq_checker #(
  parameter int WIDTH    = 10,
  parameter int MOD      = 1000,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [WIDTH-1:0] din,
  output logic             locked,
  output logic             err,
  output logic [15:0]      err_cnt,
  output logic [15:0]      wrap_cnt,
  output logic [WIDTH-1:0] expected
);

  localparam int RW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(LOSS_CNT + 1);

  localparam logic [RW-1:0]    RUN_MAX  = RW'(LOCK_CNT);
  localparam logic [MW-1:0]    MISS_MAX = MW'(LOSS_CNT);
  localparam logic [WIDTH:0]   MOD_V    = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] TOP      = WIDTH'(MOD - 1);

  localparam logic [1:0] S_UNL = 2'd0;
  localparam logic [1:0] S_SYN = 2'd1;
  localparam logic [1:0] S_LCK = 2'd2;

  logic [1:0]       st_q, st_d;
  logic [RW-1:0]    run_q, run_d;
  logic [MW-1:0]    miss_q, miss_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [15:0]      ec_q, ec_d;
  logic [15:0]      wc_q, wc_d;
  logic             lock_q, lock_d;
  logic             err_q, err_d;
  logic             oor, hit, hold;

  function automatic logic [WIDTH-1:0] nxt(
    input logic [WIDTH-1:0] x
  );
    return (x == TOP) ? '0 : x + 1'b1;
  endfunction

  function automatic logic [15:0] sat(
    input logic [15:0] x
  );
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  assign oor = {1'b0, din} >= MOD_V;
  assign hit = (din == exp_q);

`ifdef SEQ_CHK_HOLD_EN
  logic [WIDTH-1:0] last_q;

  assign hold = (st_q != S_UNL) && (din == last_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= '0;
    end else if (valid && !oor && !hold) begin
      last_q <= din;
    end
  end
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    st_d   = st_q;
    run_d  = run_q;
    miss_d = miss_q;
    exp_d  = exp_q;
    ec_d   = ec_q;
    wc_d   = wc_q;
    err_d  = 1'b0;
    if (valid) begin
      unique case (1'b1)
        st_q == S_UNL: begin
          if (!oor) begin
            exp_d = nxt(din);
            run_d = RW'(1);
            st_d  = (LOCK_CNT == 1) ? S_LCK : S_SYN;
          end
        end
        st_q == S_SYN: begin
          if (oor) begin
            st_d  = S_UNL;
            run_d = '0;
          end else if (hit) begin
            exp_d = nxt(din);
            run_d = run_q + 1'b1;
            if (run_d == RUN_MAX) begin
              st_d   = S_LCK;
              miss_d = '0;
            end
          end else if (!hold) begin
            run_d = RW'(1);
            exp_d = nxt(din);
          end
        end
        default: begin
          if (hit) begin
            exp_d  = nxt(din);
            miss_d = '0;
            if (din == '0) begin
              wc_d = sat(wc_q);
            end
          end else if (!hold) begin
            // flywheel: keep counting even though the sample was wrong
            err_d  = 1'b1;
            ec_d   = sat(ec_q);
            exp_d  = nxt(exp_q);
            miss_d = miss_q + 1'b1;
            if (miss_d == MISS_MAX) begin
              st_d   = S_UNL;
              miss_d = '0;
              run_d  = '0;
            end
          end
        end
      endcase
    end
    lock_d = (st_d == S_LCK);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q   <= S_UNL;
      run_q  <= '0;
      miss_q <= '0;
      exp_q  <= '0;
      ec_q   <= '0;
      wc_q   <= '0;
      lock_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      run_q  <= run_d;
      miss_q <= miss_d;
      exp_q  <= exp_d;
      ec_q   <= ec_d;
      wc_q   <= wc_d;
      lock_q <= lock_d;
      err_q  <= err_d;
    end
  end

  assign locked   = lock_q;
  assign err      = err_q;
  assign err_cnt  = ec_q;
  assign wrap_cnt = wc_q;
  assign expected = exp_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Scoreboard bench for count_seq_checker.
// Reference model follows the sequence rules with plain integer arithmetic.
module tb_count_seq_checker;

  localparam int W        = 10;
  localparam int MOD      = 1000;
  localparam int LOCK_CNT = 4;
  localparam int LOSS_CNT = 3;

  localparam int M_UNL = 0;
  localparam int M_SYN = 1;
  localparam int M_LCK = 2;

  typedef struct packed {
    logic        l;
    logic        e;
    logic [15:0] ec;
    logic [15:0] wc;
    logic [W-1:0] ex;
  } obs_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         valid = 1'b0;
  logic [W-1:0] din = '0;
  logic         locked;
  logic         err;
  logic [15:0]  err_cnt;
  logic [15:0]  wrap_cnt;
  logic [W-1:0] expected;

  obs_t sb[$];
  int   checks = 0;
  int   failures = 0;

  int m_mode, m_exp, m_run, m_miss, m_errc, m_wrap, m_last;

  count_seq_checker #(
    .WIDTH(W),
    .MOD(MOD),
    .LOCK_CNT(LOCK_CNT),
    .LOSS_CNT(LOSS_CNT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .valid(valid),
    .din(din),
    .locked(locked),
    .err(err),
    .err_cnt(err_cnt),
    .wrap_cnt(wrap_cnt),
    .expected(expected)
  );

  always #5 clk = ~clk;

  function automatic obs_t act();
    return {locked, err, err_cnt, wrap_cnt, expected};
  endfunction

  task automatic chk(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", nm, a, e);
    end
  endtask

  task automatic chko(input string nm, input obs_t a, input obs_t e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got l=%0d e=%0d ec=%0d wc=%0d ex=%0d want l=%0d e=%0d ec=%0d wc=%0d ex=%0d",
               nm, a.l, a.e, a.ec, a.wc, a.ex, e.l, e.e, e.ec, e.wc, e.ex);
    end
  endtask

  task automatic mreset();
    m_mode = M_UNL;
    m_exp  = 0;
    m_run  = 0;
    m_miss = 0;
    m_errc = 0;
    m_wrap = 0;
    m_last = 0;
  endtask

  task automatic mstep(input logic v, input int d, output obs_t o);
    bit e_now;
    bit inr;
    bit hold;
    e_now = 1'b0;
    if (v) begin
      inr  = (d < MOD);
      hold = 1'b0;
`ifdef SEQ_CHK_HOLD_EN
      hold = (m_mode != M_UNL) && (d == m_last);
`endif
      if (m_mode == M_UNL) begin
        if (inr) begin
          m_exp  = (d + 1) % MOD;
          m_run  = 1;
          m_mode = (LOCK_CNT == 1) ? M_LCK : M_SYN;
        end
      end else if (m_mode == M_SYN) begin
        if (!inr) begin
          m_mode = M_UNL;
          m_run  = 0;
        end else if (d == m_exp) begin
          m_run++;
          m_exp = (d + 1) % MOD;
          if (m_run == LOCK_CNT) begin
            m_mode = M_LCK;
            m_miss = 0;
          end
        end else if (!hold) begin
          m_run = 1;
          m_exp = (d + 1) % MOD;
        end
      end else begin
        if (d == m_exp) begin
          m_exp  = (d + 1) % MOD;
          m_miss = 0;
          if (d == 0 && m_wrap < 65535) m_wrap++;
        end else if (!hold) begin
          e_now = 1'b1;
          if (m_errc < 65535) m_errc++;
          m_exp = (m_exp + 1) % MOD;
          m_miss++;
          if (m_miss == LOSS_CNT) begin
            m_mode = M_UNL;
            m_miss = 0;
            m_run  = 0;
          end
        end
      end
      if (inr && !hold) m_last = d;
    end
    o.l  = (m_mode == M_LCK);
    o.e  = e_now;
    o.ec = 16'(m_errc);
    o.wc = 16'(m_wrap);
    o.ex = W'(m_exp);
  endtask

  task automatic step(input logic v, input int d);
    obs_t o;
    @(negedge clk);
    valid = v;
    din   = W'(d);
    mstep(v, d, o);
    sb.push_back(o);
  endtask

  task automatic post();
    @(posedge clk);
    #2;
  endtask

  task automatic areset();
    @(posedge clk);
    #3;
    reset = 1'b0;
    valid = 1'b0;
    #1;
    chko("async_reset", act(), '0);
    mreset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chko("scoreboard", act(), e);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int   r, d, c;
    logic v;
    mreset();
    reset = 1'b0;
    valid = 1'b1;
    repeat (3) begin
      din = W'($urandom_range(0, 1023));
      @(posedge clk);
      #1;
      chko("reset_hold", act(), '0);
    end
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 4; i++) step(1'b1, i);
    post();
    chk("lock_after4", int'(locked), 1);
    chk("exp_after4", int'(expected), 4);
    for (int i = 4; i < MOD; i++) step(1'b1, i);
    step(1'b1, 0);
    post();
    chk("wrap_cnt", int'(wrap_cnt), 1);
    chk("exp_wrap", int'(expected), 1);

    for (int i = 1; i <= 500; i++) step(1'b1, i);
    step(1'b1, 777);
    post();
    chk("fly_err", int'(err), 1);
    chk("fly_errcnt", int'(err_cnt), 1);
    chk("fly_exp", int'(expected), 502);
    step(1'b1, 502);
    post();
    chk("fly_noerr", int'(err), 0);
    chk("fly_locked", int'(locked), 1);

    areset();
    for (int i = 6; i <= 9; i++) step(1'b1, i);
    post();
    chk("relock_exp", int'(expected), 10);
    repeat (3) step(1'b1, 200);
    post();
    chk("loss_locked", int'(locked), 0);
    chk("loss_err", int'(err), 1);
    chk("loss_errcnt", int'(err_cnt), 3);
    for (int i = 5; i <= 8; i++) step(1'b1, i);
    post();
    chk("reacq_locked", int'(locked), 1);

    for (int i = 9; i <= 20; i++) step(1'b1, i);
    repeat (5) step(1'b0, int'($urandom_range(0, 1023)));
    post();
    chk("gap_exp", int'(expected), 21);
    chk("gap_err", int'(err), 0);
    step(1'b1, 21);

    areset();
    step(1'b1, 1000);
    post();
    chk("oor_locked", int'(locked), 0);
    chk("oor_exp", int'(expected), 0);
    step(1'b1, 1023);

    areset();
    for (int i = 36; i <= 39; i++) step(1'b1, i);
    step(1'b1, 40);
    step(1'b1, 41);
    step(1'b1, 41);
    step(1'b1, 41);
    step(1'b1, 42);
    post();
`ifdef SEQ_CHK_HOLD_EN
    chk("hold_errcnt", int'(err_cnt), 0);
    chk("hold_locked", int'(locked), 1);
`else
    chk("rep_errcnt", int'(err_cnt), 3);
    chk("rep_locked", int'(locked), 0);
`endif

    c = int'($urandom_range(0, MOD - 1));
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      v = ($urandom_range(0, 7) != 0);
      if (r < 85) begin
        d = c;
        if (v) c = (c + 1) % MOD;
      end else if (r < 92) begin
        d = int'($urandom_range(0, MOD - 1));
      end else if (r < 96) begin
        d = int'($urandom_range(MOD, 1023));
      end else begin
        d = c;
      end
      step(v, d);
    end

    repeat (4) @(posedge clk);
    #2;
    chk("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
